// File: rtl/pad_io_ctrl.sv
// Direction controller for one bidirectional pad: arbitrates drive ownership with
// a programmable turnaround gap, synchronizes pad input, and flags valid levels/edges.
module pad_io_ctrl #(
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic drv_req,
  input  logic drv_data,
  output logic drv_grant,
  output logic pad_o,
  output logic pad_oe,
  input  logic pad_i,
  output logic rx_data,
  output logic rx_valid,
  output logic rx_edge
);

  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } state_t;

  localparam logic [4:0] TURN_LD = 5'(TURN_CYCLES);
  localparam logic [4:0] SYNC_LD = 5'(SYNC_STAGES);
  localparam logic [4:0] RXW_LD  = 5'(TURN_CYCLES + SYNC_STAGES);

  state_t                 state_r;
  logic [4:0]             cnt_r;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_valid_d_r;
  logic                   rx_data_d_r;

  assign rx_data = sync_r[SYNC_STAGES-1];

  // Direction FSM; outputs are updated together with the state transition so they stay registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= TURN_RX;
      cnt_r     <= SYNC_LD;
      pad_oe    <= 1'b0;
      pad_o     <= 1'b0;
      drv_grant <= 1'b0;
      rx_valid  <= 1'b0;
    end else begin
      pad_o <= 1'b0;
      case (state_r)
        RX: begin
          if (drv_req) begin
            state_r <= TURN_TX;
            cnt_r   <= TURN_LD;
          end else begin
            state_r <= RX;
          end
        end
        TURN_TX: begin
          if (!drv_req) begin
            state_r <= RX;
          end else if (cnt_r <= 5'd1) begin
            state_r   <= TX;
            pad_oe    <= 1'b1;
            drv_grant <= 1'b1;
            rx_valid  <= 1'b0;
            pad_o     <= drv_data;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        TX: begin
          if (!drv_req) begin
            // Receive stays invalid until the line settles and the synchronizer flushes.
            state_r   <= TURN_RX;
            cnt_r     <= RXW_LD;
            pad_oe    <= 1'b0;
            drv_grant <= 1'b0;
          end else begin
            pad_o <= drv_data;
          end
        end
        TURN_RX: begin
          if (cnt_r <= 5'd1) begin
            state_r  <= RX;
            rx_valid <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        default: begin
          state_r   <= TURN_RX;
          cnt_r     <= SYNC_LD;
          pad_oe    <= 1'b0;
          drv_grant <= 1'b0;
          rx_valid  <= 1'b0;
        end
      endcase
    end
  end

  // Pad input synchronizer and registered edge detector on the validated level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r       <= '0;
      rx_valid_d_r <= 1'b0;
      rx_data_d_r  <= 1'b0;
      rx_edge      <= 1'b0;
    end else begin
      sync_r       <= {sync_r[SYNC_STAGES-2:0], pad_i};
      rx_valid_d_r <= rx_valid;
      rx_data_d_r  <= rx_data;
      rx_edge      <= rx_valid & rx_valid_d_r & (rx_data ^ rx_data_d_r);
    end
  end

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Scoreboard bench for pad_io_ctrl: stimulus queues per-cycle expected output vectors,
// a negedge monitor pops and compares them. Vector = {pad_oe,drv_grant,pad_o,rx_valid,rx_data,rx_edge}.
module tb_pad_io_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic a_reset, a_req, a_data, a_pi;
  logic a_grant, a_pad_o, a_pad_oe, a_rx_data, a_rx_valid, a_rx_edge;
  logic b_reset, b_req, b_data, b_pi;
  logic b_grant, b_pad_o, b_pad_oe, b_rx_data, b_rx_valid, b_rx_edge;

  pad_io_ctrl u_a (
    .clock(clock), .reset(a_reset), .drv_req(a_req), .drv_data(a_data),
    .drv_grant(a_grant), .pad_o(a_pad_o), .pad_oe(a_pad_oe), .pad_i(a_pi),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_edge(a_rx_edge)
  );

  pad_io_ctrl #(.TURN_CYCLES(15), .SYNC_STAGES(4)) u_b (
    .clock(clock), .reset(b_reset), .drv_req(b_req), .drv_data(b_data),
    .drv_grant(b_grant), .pad_o(b_pad_o), .pad_oe(b_pad_oe), .pad_i(b_pi),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_edge(b_rx_edge)
  );

  typedef struct {
    int         cyc;
    bit         inst;
    logic [5:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0;

  logic [5:0] exp_rst [0:5] = '{6'b000000, 6'b000000, 6'b000110, 6'b000110, 6'b000110, 6'b000110};
  logic [5:0] exp_drv [0:16] = '{6'b000110, 6'b000110, 6'b000110, 6'b111010, 6'b110010,
                                 6'b111010, 6'b111010, 6'b110010, 6'b111010, 6'b110010,
                                 6'b110010, 6'b000010, 6'b000010, 6'b000010, 6'b000010,
                                 6'b000110, 6'b000110};
  bit         d_drv   [0:10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [5:0] exp_edge [0:12] = '{6'b000100, 6'b000100, 6'b000110, 6'b000111, 6'b000110,
                                  6'b000110, 6'b000110, 6'b000100, 6'b000101, 6'b000100,
                                  6'b000100, 6'b000100, 6'b000100};
  logic [5:0] exp_txe [0:15] = '{6'b000100, 6'b000100, 6'b000100, 6'b110000, 6'b110000,
                                 6'b110000, 6'b110010, 6'b110010, 6'b110010, 6'b000010,
                                 6'b000010, 6'b000010, 6'b000010, 6'b000110, 6'b000110,
                                 6'b000110};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input bit inst, input int c, input logic [5:0] v, input string nm);
    exp_t e;
    e.cyc  = c;
    e.inst = inst;
    e.v    = v;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clock) begin
    logic [5:0] got;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        got = sb[i].inst ? {b_pad_oe, b_grant, b_pad_o, b_rx_valid, b_rx_data, b_rx_edge}
                         : {a_pad_oe, a_grant, a_pad_o, a_rx_valid, a_rx_data, a_rx_edge};
        checks++;
        if ((got ^ sb[i].v) !== 6'b000000) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%b want=%b", sb[i].nm, cyc, got, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    a_reset = 1'b1; a_req = 1'b0; a_data = 1'b0; a_pi = 1'b1;
    b_reset = 1'b1; b_req = 1'b0; b_data = 1'b0; b_pi = 1'b0;

    // Reset held three cycles, then idle with pad_i=1.
    repeat (3) tick();
    a_reset = 1'b0;
    t0 = cyc;
    for (int k = 0; k <= 5; k++) push_exp(1'b0, t0 + k, exp_rst[k], $sformatf("reset[%0d]", k));
    for (int k = 0; k <= 5; k++) tick();

    checks++;
    if (a_pad_oe !== 1'b0) begin
      errors++;
      $display("FAIL idle pad_oe=%b want 0", a_pad_oe);
    end
    checks++;
    if (a_rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL idle rx_valid=%b want 1", a_rx_valid);
    end
    checks++;
    if (a_rx_data !== 1'b1) begin
      errors++;
      $display("FAIL idle rx_data=%b want 1", a_rx_data);
    end
    checks++;
    if (a_rx_edge !== 1'b0) begin
      errors++;
      $display("FAIL idle rx_edge=%b want 0", a_rx_edge);
    end

    // Drive cycle followed by release at cycle 10.
    t0 = cyc;
    for (int k = 0; k <= 16; k++) push_exp(1'b0, t0 + k, exp_drv[k], $sformatf("drive[%0d]", k));
    for (int k = 0; k <= 16; k++) begin
      a_req  = (k < 10);
      a_data = (k <= 10) ? d_drv[k] : 1'b0;
      tick();
    end

    // One-cycle request: aborted turnaround.
    t0 = cyc;
    for (int k = 0; k <= 5; k++) push_exp(1'b0, t0 + k, 6'b000110, $sformatf("abort[%0d]", k));
    for (int k = 0; k <= 5; k++) begin
      a_req = (k == 0);
      tick();
    end

    checks++;
    if (a_pad_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort pad_oe=%b want 0", a_pad_oe);
    end
    checks++;
    if (a_grant !== 1'b0) begin
      errors++;
      $display("FAIL abort drv_grant=%b want 0", a_grant);
    end
    checks++;
    if (a_rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort rx_valid=%b want 1", a_rx_valid);
    end

    a_pi = 1'b0;
    repeat (6) tick();

    // Edge detect in RX: pad_i 0->1 at cycle 0, 1->0 at cycle 5.
    t0 = cyc;
    for (int k = 0; k <= 12; k++) push_exp(1'b0, t0 + k, exp_edge[k], $sformatf("edge[%0d]", k));
    for (int k = 0; k <= 12; k++) begin
      a_pi = (k < 5);
      tick();
    end

    // pad_i toggles while driving: no edge, no valid.
    t0 = cyc;
    for (int k = 0; k <= 15; k++) push_exp(1'b0, t0 + k, exp_txe[k], $sformatf("txedge[%0d]", k));
    for (int k = 0; k <= 15; k++) begin
      a_req  = (k < 8);
      a_data = 1'b0;
      a_pi   = (k >= 4);
      tick();
    end

    // Wide instance: request held through reset flush, TX, then reset mid-TX.
    t0 = cyc;
    for (int k = 0; k <= 30; k++) begin
      if (k < 4)       push_exp(1'b1, t0 + k, 6'b000000, $sformatf("midrst[%0d]", k));
      else if (k < 20) push_exp(1'b1, t0 + k, 6'b000100, $sformatf("midrst[%0d]", k));
      else if (k < 23) push_exp(1'b1, t0 + k, 6'b111000, $sformatf("midrst[%0d]", k));
      else if (k < 29) push_exp(1'b1, t0 + k, 6'b000000, $sformatf("midrst[%0d]", k));
      else             push_exp(1'b1, t0 + k, 6'b000100, $sformatf("midrst[%0d]", k));
    end
    for (int k = 0; k <= 30; k++) begin
      b_reset = (k >= 22 && k <= 24);
      b_req   = (k <= 24);
      b_data  = 1'b1;
      tick();
    end

    repeat (3) tick();
    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never compared (due cyc=%0d)", sb[i].nm, sb[i].cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
